// File: rtl/ip_csum_sched.sv
// Round-robin scheduler sharing one IP header checksum core between NUM_REQ
// transmit requesters: grant, issue, wait out the core latency, return result.
module ip_csum_sched #(
  parameter int NUM_REQ      = 4,
  parameter int ID_W         = 2,
  parameter int CSUM_LATENCY = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [32*NUM_REQ-1:0]   src_addr_bus,
  input  logic [32*NUM_REQ-1:0]   dst_addr_bus,
  output logic [NUM_REQ-1:0]      done,
  output logic [15:0]             csum_out,
  output logic [ID_W-1:0]         csum_id,
  output logic                    busy,
  output logic                    csum_en,
  output logic [31:0]             csum_src,
  output logic [31:0]             csum_dst,
  input  logic [15:0]             csum_in
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [3:0]      WAIT_LAST  = 4'(CSUM_LATENCY - 1);
  localparam logic [ID_W-1:0] LAST_RESET = ID_W'(NUM_REQ - 1);

  logic [1:0]      state;
  logic [3:0]      wait_cnt;
  logic [ID_W-1:0] last_grant;
  logic            grant_vld;
  logic [ID_W-1:0] grant_idx;
  logic [31:0]     src_slot [NUM_REQ];
  logic [31:0]     dst_slot [NUM_REQ];

  // Requester index base+k, wrapped modulo NUM_REQ (k in 1..NUM_REQ).
  function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
    assign src_slot[g] = src_addr_bus[32*g +: 32];
    assign dst_slot[g] = dst_addr_bus[32*g +: 32];
  end

  // Search starts just after the previous winner, so a held request is
  // served within NUM_REQ jobs.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!grant_vld && req[rr_index(last_grant, k)]) begin
        grant_vld = 1'b1;
        grant_idx = rr_index(last_grant, k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      last_grant <= LAST_RESET;
      csum_id    <= '0;
      csum_src   <= '0;
      csum_dst   <= '0;
      csum_out   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_vld) begin
            csum_id    <= grant_idx;
            last_grant <= grant_idx;
            csum_src   <= src_slot[grant_idx];
            csum_dst   <= dst_slot[grant_idx];
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + 4'd1;
          if (wait_cnt == WAIT_LAST) begin
            csum_out <= csum_in;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs decoded from the registered state: reset clears them at once.
  assign busy    = (state != S_IDLE);
  assign csum_en = (state == S_ISSUE);

  always_comb begin
    done = '0;
    if (state == S_DONE) done[csum_id] = 1'b1;
  end

endmodule

// File: tb/tb_ip_csum_sched.sv
// Bench for ip_csum_sched: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a job-level scheduler/checksum model.
module tb_ip_csum_sched;
  localparam int N  = 4;
  localparam int L  = 3;
  localparam int L5 = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [N-1:0]     req, req5;
  logic [31:0]      src_a [N];
  logic [31:0]      dst_a [N];
  logic [31:0]      src5, dst5;
  logic [32*N-1:0]  src_bus, dst_bus, src_bus5, dst_bus5;

  logic [N-1:0] done, done5;
  logic [15:0]  csum_out, csum_out5, csum_in, csum_in5;
  logic [1:0]   csum_id, csum_id5;
  logic         busy, busy5, csum_en, csum_en5;
  logic [31:0]  csum_src, csum_dst, csum_src5, csum_dst5;

  always_comb begin
    src_bus = '0;
    dst_bus = '0;
    for (int i = 0; i < N; i++) begin
      src_bus[32*i +: 32] = src_a[i];
      dst_bus[32*i +: 32] = dst_a[i];
    end
  end
  assign src_bus5 = {32'h0, src5, 64'h0};
  assign dst_bus5 = {32'h0, dst5, 64'h0};

  ip_csum_sched #(.NUM_REQ(N), .ID_W(2), .CSUM_LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .src_addr_bus(src_bus), .dst_addr_bus(dst_bus),
    .done(done), .csum_out(csum_out), .csum_id(csum_id), .busy(busy), .csum_en(csum_en),
    .csum_src(csum_src), .csum_dst(csum_dst), .csum_in(csum_in));

  ip_csum_sched #(.NUM_REQ(N), .ID_W(2), .CSUM_LATENCY(L5)) dut5 (
    .clk(clk), .rst_n(rst_n), .req(req5), .src_addr_bus(src_bus5), .dst_addr_bus(dst_bus5),
    .done(done5), .csum_out(csum_out5), .csum_id(csum_id5), .busy(busy5), .csum_en(csum_en5),
    .csum_src(csum_src5), .csum_dst(csum_dst5), .csum_in(csum_in5));

  // Header: ver 4 / IHL 5, every other field zero, then src and dst.
  function automatic logic [15:0] ip_csum(input logic [31:0] s, input logic [31:0] d);
    logic [31:0] acc;
    acc = 32'h4500 + {16'h0, s[31:16]} + {16'h0, s[15:0]} + {16'h0, d[31:16]} + {16'h0, d[15:0]};
    acc = {16'h0, acc[15:0]} + {16'h0, acc[31:16]};
    acc = {16'h0, acc[15:0]} + {16'h0, acc[31:16]};
    return ~acc[15:0];
  endfunction

  // Core models: result valid exactly L (or L5) cycles after the enable edge.
  logic [15:0] cp3 [L];
  logic        cv3 [L];
  logic [15:0] cp5 [L5];
  logic        cv5 [L5];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < L; i++) begin cp3[i] <= '0; cv3[i] <= 1'b0; end
      for (int i = 0; i < L5; i++) begin cp5[i] <= '0; cv5[i] <= 1'b0; end
    end else begin
      cp3[0] <= ip_csum(csum_src, csum_dst);
      cv3[0] <= csum_en;
      for (int i = 1; i < L; i++) begin cp3[i] <= cp3[i-1]; cv3[i] <= cv3[i-1]; end
      cp5[0] <= ip_csum(csum_src5, csum_dst5);
      cv5[0] <= csum_en5;
      for (int i = 1; i < L5; i++) begin cp5[i] <= cp5[i-1]; cv5[i] <= cv5[i-1]; end
    end
  end
  assign csum_in  = cv3[L-1]  ? cp3[L-1]  : 16'hDEAD;
  assign csum_in5 = cv5[L5-1] ? cp5[L5-1] : 16'hDEAD;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Job-level reference: one job at a time lasting L+2 cycles after the grant.
  function automatic int rr_pick(input logic [N-1:0] r, input int ptr);
    for (int k = 1; k <= N; k++) if (r[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  int          m_timer, m_ptr, m_id;
  logic [31:0] m_src, m_dst;
  logic [15:0] m_csum;
  always @(posedge clk or negedge rst_n) begin : model
    int g;
    if (!rst_n) begin
      m_timer <= 0;
      m_ptr   <= N - 1;
      m_id    <= 0;
    end else if (m_timer == 0) begin
      g = rr_pick(req, m_ptr);
      if (g >= 0) begin
        m_timer <= L + 2;
        m_ptr   <= g;
        m_id    <= g;
        m_src   <= src_a[g];
        m_dst   <= dst_a[g];
        m_csum  <= ip_csum(src_a[g], dst_a[g]);
      end
    end else begin
      m_timer <= m_timer - 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("mon_busy", 32'(busy), 32'(m_timer != 0));
      chk("mon_en", 32'(csum_en), 32'(m_timer == L + 2));
      if (m_timer == L + 2) begin
        chk("mon_src", csum_src, m_src);
        chk("mon_dst", csum_dst, m_dst);
      end
      if (m_timer == 1) begin
        chk("mon_done", 32'(done), 32'(1 << m_id));
        chk("mon_id", 32'(csum_id), 32'(m_id));
        chk("mon_csum", 32'(csum_out), 32'(m_csum));
      end else begin
        chk("mon_no_done", 32'(done), 32'h0);
      end
    end
  end

  task automatic wait_done(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (done == '0 && n < 30);
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0; req = '0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_done"}, 32'(done), 32'h0);
    chk({tag, "_csum_out"}, 32'(csum_out), 32'h0);
    chk({tag, "_csum_id"}, 32'(csum_id), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_csum_en"}, 32'(csum_en), 32'h0);
    chk({tag, "_csum_src"}, csum_src, 32'h0);
    chk({tag, "_csum_dst"}, csum_dst, 32'h0);
  endtask

  task automatic single_job(input int id, input logic [31:0] s, input logic [31:0] d,
                            input logic [15:0] exp);
    int n;
    @(negedge clk);
    src_a[id] = s; dst_a[id] = d; req[id] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!csum_en && n < 20);
    chk("job_en", 32'(csum_en), 32'h1);
    chk("job_src", csum_src, s);
    chk("job_dst", csum_dst, d);
    n = 0;
    do begin
      @(negedge clk); n++;
      if (n == 1) chk("job_en_width", 32'(csum_en), 32'h0);
    end while (done == '0 && n < 20);
    chk("job_latency", 32'(n), 32'(L + 1));
    chk("job_done", 32'(done), 32'(1 << id));
    chk("job_id", 32'(csum_id), 32'(id));
    chk("job_csum", 32'(csum_out), 32'(exp));
    req[id] = 1'b0;
    @(negedge clk);
    chk("job_idle_busy", 32'(busy), 32'h0);
    chk("job_idle_done", 32'(done), 32'h0);
  endtask

  typedef struct {
    int          id;
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] exp;
  } vec_t;
  vec_t vt [4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cnt1, cnt_other;
    rst_n = 1'b0; req = '0; req5 = '0; src5 = '0; dst5 = '0;
    for (int i = 0; i < N; i++) begin src_a[i] = '0; dst_a[i] = '0; end
    vt[0] = '{2, 32'hC0A80002, 32'hC0A80003, 16'h39A9};
    vt[1] = '{0, 32'h0A000001, 32'h0A000002, 16'hA6FC};
    vt[2] = '{1, 32'hFFFFFFFF, 32'hFFFFFFFF, 16'hBAFF};
    vt[3] = '{3, 32'h00000000, 32'h0000BAFF, 16'h0000};

    repeat (2) @(negedge clk);
    #1 chk_reset_outputs("rst");
    chk("rst_busy5", 32'(busy5), 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // Vector table: single jobs on distinct requesters and data patterns.
    for (int i = 0; i < 4; i++) single_job(vt[i].id, vt[i].src, vt[i].dst, vt[i].exp);

    // Longer core latency instance.
    @(negedge clk); src5 = 32'hC0A80002; dst5 = 32'hC0A80003; req5[2] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!csum_en5 && n < 20);
    chk("l5_en", 32'(csum_en5), 32'h1);
    chk("l5_src", csum_src5, 32'hC0A80002);
    n = 0;
    do begin @(negedge clk); n++; end while (done5 == '0 && n < 20);
    chk("l5_latency", 32'(n), 32'(L5 + 1));
    chk("l5_done", 32'(done5), 32'h4);
    chk("l5_id", 32'(csum_id5), 32'h2);
    chk("l5_csum", 32'(csum_out5), 32'h39A9);
    req5 = '0;

    // Post-reset priority.
    do_reset();
    src_a[0] = 32'h01020304; dst_a[0] = 32'h05060708;
    src_a[3] = 32'h11223344; dst_a[3] = 32'h55667788;
    req = 4'b1001;
    wait_done(n);
    chk("prio_first", 32'(done), 32'h1);
    chk("prio_first_id", 32'(csum_id), 32'h0);
    req[0] = 1'b0;
    wait_done(n);
    chk("prio_second", 32'(done), 32'h8);
    chk("prio_second_id", 32'(csum_id), 32'h3);
    chk("prio_spacing", 32'(n), 32'(L + 3));
    req[3] = 1'b0;

    // Fairness with all requests held.
    do_reset();
    for (int i = 0; i < N; i++) begin src_a[i] = $urandom; dst_a[i] = $urandom; end
    req = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      wait_done(n);
      chk("fair_order", 32'(done), 32'(1 << (k % N)));
      if (k > 0) chk("fair_spacing", 32'(n), 32'(L + 3));
    end
    req = '0;
    repeat (2) @(negedge clk);
    chk("fair_idle", 32'(busy), 32'h0);

    // Abandoned request: one-cycle pulse still completes once.
    @(negedge clk); src_a[1] = 32'hAC100001; dst_a[1] = 32'hAC100002; req[1] = 1'b1;
    @(negedge clk); req[1] = 1'b0;
    cnt1 = 0; cnt_other = 0;
    for (int c = 0; c < 12; c++) begin
      if (done[1]) cnt1++;
      if ((done & 4'b1101) != '0) cnt_other++;
      @(negedge clk);
    end
    chk("aband_done_cnt", 32'(cnt1), 32'h1);
    chk("aband_other", 32'(cnt_other), 32'h0);
    chk("aband_idle", 32'(busy), 32'h0);

    // Reset during the second WAIT cycle.
    @(negedge clk); src_a[0] = 32'hC0A80101; dst_a[0] = 32'hC0A80102; req[0] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!csum_en && n < 20);
    chk("mid_en", 32'(csum_en), 32'h1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("mid");
    req[0] = 1'b0;
    cnt1 = 0;
    for (int c = 0; c < 3; c++) begin @(negedge clk); if (done != '0) cnt1++; end
    chk("mid_no_done", 32'(cnt1), 32'h0);
    rst_n = 1'b1;
    single_job(0, 32'hC0A80002, 32'hC0A80003, ip_csum(32'hC0A80002, 32'hC0A80003));

    // Randomized traffic against the reference model.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (done[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 3) == 0) begin
          src_a[i] = $urandom; dst_a[i] = $urandom; req[i] = 1'b1;
        end
      end
    end
    // Drain: let the in-flight job finish, leave the rest unserved.
    req = '0;
    n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 20);
    chk("drain_idle", 32'(busy), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ip_csum_sched.md
Name: ip_csum_sched

Overview:
- Round-robin scheduler that shares one IP header checksum core between NUM_REQ transmit requesters. Typical requesters are per-channel UDP/IP frame builders.
- Each granted job:
  - registers that requester's source and destination IP addresses;
  - pulses the core enable for one cycle;
  - waits the core's fixed pipeline latency;
  - captures the 16-bit checksum and returns it with a one-cycle done pulse to the owning requester.
- Sits between the frame-builder channels and the checksum core in the gigabit Ethernet TX path.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- ID_W, 2: width of the requester index; must be ≥ clog2(NUM_REQ).
- CSUM_LATENCY, 3: cycles from the enable being sampled by the core until the checksum output is valid (range 1..15).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- req  in  NUM_REQ  per-requester job request (level)
- src_addr_bus  in  32*NUM_REQ  source IPs; requester i on bits [32i+31:32i]
- dst_addr_bus  in  32*NUM_REQ  destination IPs, same packing
- done  out  NUM_REQ  one-cycle completion pulse, one-hot to the owning requester
- csum_out  out  16  captured checksum; holds until the next capture
- csum_id  out  ID_W  index of the job currently owned or last completed
- busy  out  1  high in every state except IDLE
- csum_en  out  1  to core: one-cycle calculate strobe
- csum_src  out  32  to core: source IP, registered
- csum_dst  out  32  to core: destination IP, registered
- csum_in  in  16  from core: checksum result

Behaviour:
- Reset values:
  - state=IDLE, done=0, csum_out=0, csum_id=0, busy=0, csum_en=0, csum_src=0, csum_dst=0;
  - wait counter=0, rr pointer last_grant=NUM_REQ-1, so requester 0 has highest priority after reset.
- State machine: IDLE → ISSUE → WAIT → DONE → IDLE.
- IDLE:
  - If req≠0, grant the first asserted requester searching last_grant+1, +2, … with modulo NUM_REQ wrap.
  - Register csum_id=grant, last_grant=grant, and csum_src/csum_dst from that requester's slice; go to ISSUE.
  - If req=0, stay in IDLE.
- ISSUE (cycle T):
  - csum_en=1 for exactly this cycle; addresses are stable.
  - Clear the counter; go to WAIT.
- WAIT (cycles T+1 … T+CSUM_LATENCY):
  - Counter increments each cycle; csum_src/csum_dst are held.
  - When counter == CSUM_LATENCY-1, register csum_out ← csum_in at the end of that cycle; go to DONE.
- DONE (cycle T+CSUM_LATENCY+1):
  - done[csum_id]=1 for this cycle only; csum_out is valid and stays valid afterwards; go to IDLE.
- Job timing:
  - Latency from the grant decision to done is CSUM_LATENCY+2 cycles.
  - Throughput is one job per CSUM_LATENCY+3 cycles.
- Requester contract:
  - Hold req and the address slice stable until done is seen, then deassert req by the next cycle.
  - A req still high in the IDLE cycle after DONE is treated as a new job.
- Edge cases:
  - req dropped mid-job: the job still completes, and done still pulses to that index; no abort.
  - Addresses changing after the grant: ignored, since the addresses are registered in IDLE.
  - Simultaneous requests: exactly one grant per arbitration; the rr pointer guarantees that any held request is served within NUM_REQ jobs.
  - Requests arriving while busy: not sampled until IDLE.
- done is never asserted on more than one bit, and never in any state except DONE.
- rst_n asserted mid-job: all state clears immediately, with no done pulse. The in-flight result is discarded; the core shares rst_n.

Test Plan:
- Single job with the core at its default header fields (ver 4, IHL 5, all other fields 0): req[2]=1, src=C0A80002, dst=C0A80003.
  - Expect csum_en high exactly 1 cycle with csum_src=C0A80002 and csum_dst=C0A80003.
  - Expect done=4'b0100 exactly CSUM_LATENCY+1=4 cycles after csum_en.
  - Expect csum_out=16'h39A9 and csum_id=2.
- Post-reset priority: req=4'b1001 asserted together.
  - Expect the first grant to be id 0 and the second to be id 3; each done pulses to its own bit only.
- Fairness: req=4'b1111 held, each requester re-asserting after its done.
  - Expect grant order 0,1,2,3,0,1 and job spacing of 6 cycles (CSUM_LATENCY+3).
- Abandoned request: req[1] pulsed for 1 cycle only.
  - Expect the job to still complete and done[1] to pulse once; afterwards busy=0 and the scheduler is idle.
- Reset mid-WAIT: assert rst_n=0 during the second WAIT cycle.
  - Expect all outputs at reset values immediately and no done pulse.
  - After release, a new req[0] completes normally with the correct checksum.
- Latency parameter: rebuild with CSUM_LATENCY=5 and a matching core model.
  - Expect done 6 cycles after csum_en and csum_out equal to the core output in its first valid cycle.
